// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port among NUM_REQ
// requesters. One word is in flight at a time; a word completes only on the
// FIFO's wr_ack. Overflow or a missing acknowledge re-issues the same
// requester's word before anyone else is considered.
module fifo_wr_arbiter #(
   parameter int FIFO_WIDTH  = 16,
   parameter int NUM_REQ     = 4,
   parameter int ACK_TIMEOUT = 7
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_done,
   input  logic                            fifo_full,
   input  logic                            fifo_wr_ack,
   input  logic                            fifo_overflow,
   output logic                            fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]           fifo_data_in,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            busy,
   output logic [7:0]                      retry_cnt,
   output logic                            err_timeout
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_q,  state_d;
   logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
   logic                    retry_q,  retry_d;
   logic [GW-1:0]           grant_q,  grant_d;
   logic [FIFO_WIDTH-1:0]   data_q,   data_d;
   logic                    wr_en_q,  wr_en_d;
   logic [NUM_REQ-1:0]      done_q,   done_d;
   logic [3:0]              wcnt_q,   wcnt_d;
   logic [7:0]              rcnt_q,   rcnt_d;
   logic                    err_q,    err_d;

   logic                    pick_found;
   logic [GW-1:0]           pick_idx;
   logic [GW-1:0]           cand;
   logic [GW-1:0]           sel_idx;
   logic [FIFO_WIDTH-1:0]   sel_data;

   // Round-robin search from rr_ptr upward; a pending retry overrides it.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
      sel_idx  = retry_q ? grant_q : pick_idx;
      sel_data = req_data[int'(sel_idx)*FIFO_WIDTH +: FIFO_WIDTH];
   end

   // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/DONE FSM.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      retry_d  = retry_q;
      grant_d  = grant_q;
      data_d   = data_q;
      wr_en_d  = 1'b0;
      done_d   = '0;
      wcnt_d   = wcnt_q;
      rcnt_d   = rcnt_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            // A retry proceeds even if the requester dropped valid, so the
            // granted word always completes once it has been started.
            if (!fifo_full && (retry_q || pick_found)) begin
               grant_d = sel_idx;
               data_d  = sel_data;
               wr_en_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            wcnt_d  = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (fifo_wr_ack) begin
               done_d[grant_q] = 1'b1;
               state_d         = ST_DONE;
            end else if (fifo_overflow) begin
               retry_d = 1'b1;
               if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
               state_d = ST_IDLE;
            end else if (wcnt_q == 4'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               retry_d = 1'b1;
               if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end

         ST_DONE: begin
            // Skip arbitration here so a requester still showing its old
            // word cannot be granted again before it updates req_data.
            rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            retry_d  = 1'b0;
            state_d  = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; asynchronous reset abandons any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         retry_q  <= 1'b0;
         grant_q  <= '0;
         data_q   <= '0;
         wr_en_q  <= 1'b0;
         done_q   <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         retry_q  <= retry_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         wr_en_q  <= wr_en_d;
         done_q   <= done_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
         err_q    <= err_d;
      end
   end

   assign req_done     = done_q;
   assign fifo_wr_en   = wr_en_q;
   assign fifo_data_in = data_q;
   assign grant_id     = grant_q;
   assign busy         = (state_q != ST_IDLE);
   assign retry_cnt    = rcnt_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a FIFO write-side responder plus a queue of
// expected (grant_id, data) writes checked each time fifo_wr_en rises.
module tb_fifo_wr_arbiter;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int GW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*W-1:0]  req_data = '0;
   logic [N-1:0]    req_done;
   logic            fifo_full = 1'b0;
   logic            fifo_wr_ack = 1'b0;
   logic            fifo_overflow = 1'b0;
   logic            fifo_wr_en;
   logic [W-1:0]    fifo_data_in;
   logic [GW-1:0]   grant_id;
   logic            busy;
   logic [7:0]      retry_cnt;
   logic            err_timeout;

   typedef struct packed {
      logic [GW-1:0] gid;
      logic [W-1:0]  data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Responder controls: written only by the test sequence.
   int   ovf_target = 0;
   bit   resp_none  = 1'b0;
   // Responder state: written only by the responder.
   int   ovf_done   = 0;
   logic prev_wr    = 1'b0;

   fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .ACK_TIMEOUT(7)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_done(req_done), .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack),
      .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en),
      .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy),
      .retry_cnt(retry_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: answers a write one cycle after wr_en with overflow (while
   // overflows are still owed) or ack, unless told to stay silent.
   always @(negedge clk) begin
      fifo_wr_ack   = 1'b0;
      fifo_overflow = 1'b0;
      if (prev_wr && !resp_none && !rst) begin
         if (ovf_done < ovf_target) begin
            fifo_overflow = 1'b1;
            ovf_done++;
         end else begin
            fifo_wr_ack = 1'b1;
         end
      end
      prev_wr = fifo_wr_en;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_word(input int i, input logic [W-1:0] w);
      req_data[i*W +: W] = w;
   endtask

   task automatic wait_wr(output int waited, output bit ok);
      waited = 0;
      ok     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         waited++;
         if (fifo_wr_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++; if (req_done !== 4'b0)    $display("FAIL rst_req_done: got %b want 0000", req_done); else n_pass++;
      n_checks++; if (fifo_wr_en !== 1'b0)  $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); else n_pass++;
      n_checks++; if (fifo_data_in !== 16'h0) $display("FAIL rst_data: got %h want 0000", fifo_data_in); else n_pass++;
      n_checks++; if (grant_id !== 2'd0)    $display("FAIL rst_grant: got %0d want 0", grant_id); else n_pass++;
      n_checks++; if (busy !== 1'b0)        $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (retry_cnt !== 8'd0)   $display("FAIL rst_retry_cnt: got %0d want 0", retry_cnt); else n_pass++;
      n_checks++; if (err_timeout !== 1'b0) $display("FAIL rst_err: got %b want 0", err_timeout); else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_single();
      int waited; bit ok; exp_t e;
      set_word(0, 16'hA5A5);
      req_valid = 4'b0001;
      exp_q.push_back('{gid: 2'd0, data: 16'hA5A5});
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || waited != 1) $display("FAIL single_latency: got %0d cycles (seen=%0b) want 1", waited, ok); else n_pass++;
      n_checks++; if (grant_id !== e.gid) $display("FAIL single_grant: got %0d want %0d", grant_id, e.gid); else n_pass++;
      n_checks++; if (fifo_data_in !== e.data) $display("FAIL single_data: got %h want %h", fifo_data_in, e.data); else n_pass++;
      tick();
      n_checks++; if (fifo_wr_en !== 1'b0) $display("FAIL single_wr_pulse: got %b want 0", fifo_wr_en); else n_pass++;
      n_checks++; if (req_done !== 4'b0) $display("FAIL single_done_early: got %b want 0000", req_done); else n_pass++;
      tick();
      n_checks++; if (req_done !== 4'b0001) $display("FAIL single_done: got %b want 0001", req_done); else n_pass++;
      req_valid = 4'b0000;
      tick();
      n_checks++; if (busy !== 1'b0 || req_done !== 4'b0) $display("FAIL single_after: busy=%b done=%b want 0 0000", busy, req_done); else n_pass++;
   endtask

   task automatic test_fairness();
      int waited; bit ok; exp_t e;
      int order[6] = '{0, 1, 2, 3, 0, 1};
      int k[4] = '{0, 0, 0, 0};
      int last_done = 0;
      logic [GW-1:0] prev_gid = '0;
      for (int i = 0; i < N; i++) set_word(i, 16'((i + 1) * 4096));
      for (int w = 0; w < 6; w++) begin
         exp_q.push_back('{gid: GW'(order[w]), data: 16'((order[w] + 1) * 4096 + k[order[w]])});
         k[order[w]]++;
      end
      req_valid = 4'b1111;
      for (int w = 0; w < 6; w++) begin
         wait_wr(waited, ok);
         e = exp_q.pop_front();
         n_checks++; if (!ok) $display("FAIL fair_wr_seen: word %0d no write within bound", w); else n_pass++;
         n_checks++; if (grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL fair_write: word %0d got %0d/%h want %0d/%h", w, grant_id, fifo_data_in, e.gid, e.data); else n_pass++;
         if (w > 0) begin
            n_checks++; if (grant_id === prev_gid) $display("FAIL fair_repeat: word %0d got %0d twice want different", w, grant_id); else n_pass++;
         end
         prev_gid = grant_id;
         tick();
         tick();
         n_checks++; if (req_done !== 4'(1 << e.gid)) $display("FAIL fair_done: word %0d got %b want %b", w, req_done, 4'(1 << e.gid)); else n_pass++;
         if (w > 0) begin
            n_checks++; if (cyc - last_done != 4) $display("FAIL fair_rate: word %0d got %0d cycles want 4", w, cyc - last_done); else n_pass++;
         end
         last_done = cyc;
         set_word(int'(e.gid), 16'((int'(e.gid) + 1) * 4096 + k[e.gid] - 1 + ((w >= 4) ? 1 : 0)));
         if (w == 5) req_valid = 4'b0000;
      end
      tick();
   endtask

   task automatic test_full_stall();
      int waited; bit ok; exp_t e;
      set_word(1, 16'hF00D);
      req_valid = 4'b0010;
      fifo_full = 1'b1;
      exp_q.push_back('{gid: 2'd1, data: 16'hF00D});
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL full_stall: cycle %0d wr_en=%b busy=%b want 0 0", i, fifo_wr_en, busy); else n_pass++;
      end
      fifo_full = 1'b0;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || waited != 1) $display("FAIL full_release: got %0d cycles (seen=%0b) want 1", waited, ok); else n_pass++;
      n_checks++; if (grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL full_write: got %0d/%h want %0d/%h", grant_id, fifo_data_in, e.gid, e.data); else n_pass++;
      tick();
      tick();
      n_checks++; if (req_done !== 4'b0010) $display("FAIL full_done: got %b want 0010", req_done); else n_pass++;
      req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_overflow_retry();
      int waited; bit ok; exp_t e;
      set_word(0, 16'h0A0A);
      set_word(2, 16'h1234);
      set_word(3, 16'h3333);
      ovf_target = ovf_target + 1;
      exp_q.push_back('{gid: 2'd2, data: 16'h1234});
      exp_q.push_back('{gid: 2'd2, data: 16'h1234});
      exp_q.push_back('{gid: 2'd3, data: 16'h3333});
      req_valid = 4'b1101;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL ovf_first: got %0d/%h want %0d/%h", grant_id, fifo_data_in, e.gid, e.data); else n_pass++;
      tick();
      tick();
      n_checks++; if (retry_cnt !== 8'd1) $display("FAIL ovf_retry_cnt: got %0d want 1", retry_cnt); else n_pass++;
      n_checks++; if (req_done !== 4'b0 || busy !== 1'b0) $display("FAIL ovf_no_done: done=%b busy=%b want 0000 0", req_done, busy); else n_pass++;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || waited != 1 || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL ovf_reissue: got %0d/%h after %0d want %0d/%h after 1", grant_id, fifo_data_in, waited, e.gid, e.data); else n_pass++;
      tick();
      tick();
      n_checks++; if (req_done !== 4'b0100) $display("FAIL ovf_done: got %b want 0100", req_done); else n_pass++;
      req_valid[2] = 1'b0;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL ovf_next_grant: got %0d/%h want %0d/%h", grant_id, fifo_data_in, e.gid, e.data); else n_pass++;
      tick();
      tick();
      n_checks++; if (req_done !== 4'b1000) $display("FAIL ovf_done3: got %b want 1000", req_done); else n_pass++;
      req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      int waited; bit ok; exp_t e;
      resp_none = 1'b1;
      set_word(0, 16'hBEEF);
      exp_q.push_back('{gid: 2'd0, data: 16'hBEEF});
      exp_q.push_back('{gid: 2'd0, data: 16'hBEEF});
      req_valid = 4'b0001;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL to_first: got %0d/%h want %0d/%h", grant_id, fifo_data_in, e.gid, e.data); else n_pass++;
      for (int j = 0; j < 7; j++) begin
         tick();
         n_checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) $display("FAIL to_wait: cycle %0d busy=%b err=%b want 1 0", j, busy, err_timeout); else n_pass++;
      end
      tick();
      n_checks++; if (err_timeout !== 1'b1) $display("FAIL to_err: got %b want 1", err_timeout); else n_pass++;
      n_checks++; if (retry_cnt !== 8'd2 || busy !== 1'b0) $display("FAIL to_retry_cnt: cnt=%0d busy=%b want 2 0", retry_cnt, busy); else n_pass++;
      resp_none = 1'b0;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || waited != 1 || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL to_reissue: got %0d/%h after %0d want %0d/%h after 1", grant_id, fifo_data_in, waited, e.gid, e.data); else n_pass++;
      tick();
      tick();
      n_checks++; if (req_done !== 4'b0001) $display("FAIL to_done: got %b want 0001", req_done); else n_pass++;
      req_valid = 4'b0000;
      tick();
      tick();
      n_checks++; if (err_timeout !== 1'b1 || retry_cnt !== 8'd2) $display("FAIL to_sticky: err=%b cnt=%0d want 1 2", err_timeout, retry_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      int waited; bit ok; exp_t e;
      resp_none = 1'b1;
      set_word(2, 16'h5A5A);
      exp_q.push_back('{gid: 2'd2, data: 16'h5A5A});
      exp_q.push_back('{gid: 2'd2, data: 16'h5A5A});
      req_valid = 4'b0100;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL mrst_first: got %0d/%h want %0d/%h", grant_id, fifo_data_in, e.gid, e.data); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL mrst_in_wait: busy=%b want 1", busy); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({req_done, fifo_wr_en, busy, err_timeout} !== 7'b0) $display("FAIL mrst_ctrl: done=%b wr=%b busy=%b err=%b want all 0", req_done, fifo_wr_en, busy, err_timeout); else n_pass++;
      n_checks++; if (fifo_data_in !== 16'h0 || grant_id !== 2'd0 || retry_cnt !== 8'd0) $display("FAIL mrst_data: data=%h grant=%0d cnt=%0d want 0000 0 0", fifo_data_in, grant_id, retry_cnt); else n_pass++;
      tick();
      n_checks++; if (req_done !== 4'b0) $display("FAIL mrst_no_done: got %b want 0000", req_done); else n_pass++;
      resp_none = 1'b0;
      tick();
      rst = 1'b0;
      wait_wr(waited, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || waited != 1 || grant_id !== e.gid || fifo_data_in !== e.data) $display("FAIL mrst_regrant: got %0d/%h after %0d want %0d/%h after 1", grant_id, fifo_data_in, waited, e.gid, e.data); else n_pass++;
      tick();
      tick();
      n_checks++; if (req_done !== 4'b0100) $display("FAIL mrst_done: got %b want 0100", req_done); else n_pass++;
      req_valid = 4'b0000;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      do_reset();
      test_fairness();
      test_full_stall();
      test_overflow_retry();
      test_timeout();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
